// File: rtl/lsu_issue_queue_pkg.sv
// rtl/lsu_issue_queue_pkg.sv - shared constants and entry layout for the LSU issue queue
package lsu_issue_queue_pkg;

  // Default ROB/physical tag width used for wakeup and writeback.
  localparam int unsigned IQ_TAG_W = 4;

  // Major opcodes shared with the LSU decode.
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Per-entry payload that travels unchanged from dispatch to the LSU.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } iq_meta_t;

  // Loads have no rs2 data operand.
  function automatic logic is_load(input logic [6:0] opcode);
    return opcode == OP_LOAD;
  endfunction

endpackage

// File: rtl/lsu_issue_queue_iq_operand_slot.sv
// rtl/lsu_issue_queue_iq_operand_slot.sv - one source operand: ready/tag/value with bypass and wakeup
module iq_operand_slot
  import lsu_issue_queue_pkg::*;
#(
  parameter int unsigned TAG_W = IQ_TAG_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alloc_i,
  input  logic             entry_valid_i,
  input  logic             disp_ready_i,
  input  logic [TAG_W-1:0] disp_tag_i,
  input  logic [31:0]      disp_value_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  output logic             ready_o,
  output logic [31:0]      value_o
);

  logic             ready_q, ready_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      value_q, value_d;

  // Allocation takes the dispatch value, or the CDB value when the producer broadcasts
  // in the dispatch cycle; otherwise a waiting operand captures a matching broadcast once.
  always_comb begin
    ready_d = ready_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (alloc_i) begin
      tag_d = disp_tag_i;
      if (disp_ready_i) begin
        ready_d = 1'b1;
        value_d = disp_value_i;
      end else if (cdb_valid_i && (cdb_tag_i == disp_tag_i)) begin
        ready_d = 1'b1;
        value_d = cdb_value_i;
      end else begin
        ready_d = 1'b0;
        value_d = '0;
      end
    end else if (entry_valid_i && !ready_q && cdb_valid_i && (cdb_tag_i == tag_q)) begin
      ready_d = 1'b1;
      value_d = cdb_value_i;
    end
  end

  // Operand state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_q <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      ready_q <= ready_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign ready_o = ready_q;
  assign value_o = value_q;

endmodule

// File: rtl/lsu_issue_queue.sv
// rtl/lsu_issue_queue.sv - in-order load/store issue queue feeding the LSU
module lsu_issue_queue
  import lsu_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned TAG_W = IQ_TAG_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             disp_valid_i,
  output logic             disp_ready_o,
  input  logic [31:0]      disp_inst_i,
  input  logic [31:0]      disp_pc_i,
  input  logic [TAG_W-1:0] disp_rob_tag_i,
  input  logic             disp_rs1_ready_i,
  input  logic [TAG_W-1:0] disp_rs1_tag_i,
  input  logic [31:0]      disp_rs1_value_i,
  input  logic             disp_rs2_ready_i,
  input  logic [TAG_W-1:0] disp_rs2_tag_i,
  input  logic [31:0]      disp_rs2_value_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_value_i,
  input  logic             lsu_busy_i,
  output logic             lsu_request_o,
  output logic [31:0]      lsu_inst_o,
  output logic [31:0]      lsu_pc_o,
  output logic [31:0]      lsu_rs1_value_o,
  output logic [31:0]      lsu_rs2_value_o,
  output logic [TAG_W-1:0] lsu_rob_tag_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q;
  iq_meta_t         meta_q    [DEPTH];
  logic [TAG_W-1:0] rob_tag_q [DEPTH];

  logic [DEPTH-1:0] rs1_rdy, rs2_rdy;
  logic [31:0]      rs1_val [DEPTH];
  logic [31:0]      rs2_val [DEPTH];

  logic             full, empty, push, pop;
  logic             disp_is_load, disp_rs2_rdy;
  logic [31:0]      disp_rs2_val;

  logic             lsu_request_q;
  logic [31:0]      lsu_inst_q, lsu_pc_q, lsu_rs1_q, lsu_rs2_q;
  logic [TAG_W-1:0] lsu_rob_tag_q;

  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign disp_ready_o = !full;

  // Loads never wait on rs2: it is forced ready with a zero value.
  assign disp_is_load = is_load(disp_inst_i[6:0]);
  assign disp_rs2_rdy = disp_rs2_ready_i | disp_is_load;
  assign disp_rs2_val = disp_is_load ? 32'd0 : disp_rs2_value_i;

  // A flush discards any push or issue presented in the same cycle.
  assign push = disp_valid_i && !full && !flush_i;
  assign pop  = !empty && rs1_rdy[head_q] && rs2_rdy[head_q] && !lsu_busy_i && !flush_i;

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PTR_ONE;
    if (push) tail_d = tail_q + PTR_ONE;
    if (push && !pop) count_d = count_q + CNT_ONE;
    if (pop && !push) count_d = count_q - CNT_ONE;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic alloc;
    assign alloc = push && (tail_q == PTR_W'(i));

    iq_operand_slot #(.TAG_W(TAG_W)) u_rs1 (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .alloc_i       (alloc),
      .entry_valid_i (valid_q[i]),
      .disp_ready_i  (disp_rs1_ready_i),
      .disp_tag_i    (disp_rs1_tag_i),
      .disp_value_i  (disp_rs1_value_i),
      .cdb_valid_i   (cdb_valid_i),
      .cdb_tag_i     (cdb_tag_i),
      .cdb_value_i   (cdb_value_i),
      .ready_o       (rs1_rdy[i]),
      .value_o       (rs1_val[i])
    );

    iq_operand_slot #(.TAG_W(TAG_W)) u_rs2 (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .alloc_i       (alloc),
      .entry_valid_i (valid_q[i]),
      .disp_ready_i  (disp_rs2_rdy),
      .disp_tag_i    (disp_rs2_tag_i),
      .disp_value_i  (disp_rs2_val),
      .cdb_valid_i   (cdb_valid_i),
      .cdb_tag_i     (cdb_tag_i),
      .cdb_value_i   (cdb_value_i),
      .ready_o       (rs2_rdy[i]),
      .value_o       (rs2_val[i])
    );
  end

  // Queue bookkeeping and entry payload capture at the tail.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        meta_q[i]    <= '0;
        rob_tag_q[i] <= '0;
      end
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (pop) valid_q[head_q] <= 1'b0;
      if (push) begin
        valid_q[tail_q]   <= 1'b1;
        meta_q[tail_q]    <= '{inst: disp_inst_i, pc: disp_pc_i};
        rob_tag_q[tail_q] <= disp_rob_tag_i;
      end
    end
  end

  // Registered one-cycle LSU request; data holds between requests.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lsu_request_q <= 1'b0;
      lsu_inst_q    <= '0;
      lsu_pc_q      <= '0;
      lsu_rs1_q     <= '0;
      lsu_rs2_q     <= '0;
      lsu_rob_tag_q <= '0;
    end else begin
      lsu_request_q <= pop;
      if (pop) begin
        lsu_inst_q    <= meta_q[head_q].inst;
        lsu_pc_q      <= meta_q[head_q].pc;
        lsu_rs1_q     <= rs1_val[head_q];
        lsu_rs2_q     <= rs2_val[head_q];
        lsu_rob_tag_q <= rob_tag_q[head_q];
      end
    end
  end

  assign lsu_request_o   = lsu_request_q;
  assign lsu_inst_o      = lsu_inst_q;
  assign lsu_pc_o        = lsu_pc_q;
  assign lsu_rs1_value_o = lsu_rs1_q;
  assign lsu_rs2_value_o = lsu_rs2_q;
  assign lsu_rob_tag_o   = lsu_rob_tag_q;
  assign count_o         = count_q;

endmodule

// File: doc/lsu_issue_queue.md
Name: lsu_issue_queue

Overview:
In-order issue queue directly upstream of the load-store unit. It accepts load/store instructions from dispatch and holds each one until both of its source operands are available. Operands arrive either at dispatch time or by snooping the common data bus (CDB). The head entry is issued to the LSU as a one-cycle request carrying the instruction and both resolved register values. Issue is strictly in program order, so memory ordering is preserved without address disambiguation.

Parameters:
DEPTH, 4, number of queue entries; must be a power of two, at least 2.
PTR_W, 2, log2(DEPTH).
TAG_W, 4, width of ROB/physical tag used for operand wakeup and writeback.

Ports:
clk_i  input  1  clock, all state updates on rising edge.
reset_i  input  1  asynchronous, active-high reset.
flush_i  input  1  synchronous squash of all entries and of the pending LSU request.
disp_valid_i  input  1  dispatch presents a load/store.
disp_ready_o  output  1  queue can accept this cycle; equals !full.
disp_inst_i  input  32  raw instruction.
disp_pc_i  input  32  instruction PC.
disp_rob_tag_i  input  TAG_W  ROB tag of this instruction; forwarded to the LSU.
disp_rs1_ready_i  input  1  rs1 value valid at dispatch.
disp_rs1_tag_i  input  TAG_W  producer tag when rs1 is not ready.
disp_rs1_value_i  input  32  rs1 value when ready.
disp_rs2_ready_i, disp_rs2_tag_i, disp_rs2_value_i  input  1/TAG_W/32  same as rs1, for rs2.
cdb_valid_i  input  1  result broadcast valid.
cdb_tag_i  input  TAG_W  broadcast tag.
cdb_value_i  input  32  broadcast value.
lsu_busy_i  input  1  LSU cannot accept (load/store buffer full).
lsu_request_o  output  1  registered one-cycle issue pulse to the LSU.
lsu_inst_o  output  32  issued instruction.
lsu_pc_o  output  32  issued PC.
lsu_rs1_value_o  output  32  issued rs1 value.
lsu_rs2_value_o  output  32  issued rs2 value.
lsu_rob_tag_o  output  TAG_W  issued ROB tag.
count_o  output  PTR_W+1  current occupancy.

Behaviour:
- Storage: circular buffer with head/tail pointers of PTR_W bits that wrap modulo DEPTH, plus a PTR_W+1-bit count. full = (count == DEPTH); empty = (count == 0).
- Per-entry fields: valid, inst, pc, rob_tag, and for each operand a ready bit, a tag and a value.
- Loads: when disp_inst_i[6:0] == 7'b0000011, rs2 is forced ready with value 0, independent of disp_rs2_ready_i.
- Push: on an edge where disp_valid_i && disp_ready_o, the entry is written at tail, tail advances and count increments.
- Dispatch bypass: a source that is not ready at dispatch, but whose tag equals cdb_tag_i while cdb_valid_i is high in the same cycle, is written as ready with cdb_value_i.
- Wakeup: every cycle, each valid entry with a not-ready operand whose tag == cdb_tag_i && cdb_valid_i sets ready and captures cdb_value_i. One CDB port only; several entries may wake on the same broadcast.
- Issue condition (cycle C): !empty && head.rs1_ready && head.rs2_ready && !lsu_busy_i && !flush_i. Non-head entries never issue, even if they are ready.
- Issue timing: on the edge ending cycle C, the head pops (head advances, count decrements) and all lsu_* output registers load from the head entry. lsu_request_o is 1 in cycle C+1 only; otherwise it is 0. Output data registers hold their last values when no request is made.
- Latency: an instruction dispatched with ready operands in cycle N issues at the end of N+1, so lsu_request_o is high in N+2. Throughput is one issue per cycle while the LSU is not busy.
- Wakeup and issue: a head operand woken by the CDB in cycle C becomes ready at the end of C and can issue at the end of C+1. There is no same-cycle wakeup-to-issue path.
- Simultaneous push and pop: allowed when not full; count is unchanged and both pointers advance. When full, disp_ready_o = 0 even if a pop happens in the same cycle; there is no full-cycle fall-through.
- Flush: on an edge with flush_i = 1, all valid bits, head, tail and count clear and lsu_request_o is 0 next cycle. A push or issue in the same cycle as the flush is discarded.
- Reset (asynchronous): head = tail = count = 0, all valid bits = 0, lsu_request_o = 0, all lsu_* data outputs = 0. disp_ready_o = 1 and count_o = 0 immediately after reset. A reset mid-operation drops everything in flight.
- Tags are compared at full TAG_W width. CDB data is captured only for entries that are not yet ready; already-ready operands are never overwritten.

Decomposition:
- Shared package: TAG_W default, OP_LOAD/OP_STORE opcode constants (already used by the LSU decode), and the entry field layout.
- One natural sub-module: iq_operand_slot. It holds one operand's ready/tag/value and implements the dispatch-bypass and CDB-wakeup capture. It is instantiated twice per entry through a generate loop.

Test Plan:
- Reset release, dispatch one LW with both operands ready (rs1 = 0x100, rob_tag = 3) in cycle 1 -> lsu_request_o = 1 in cycle 3 only, lsu_rs1_value_o = 0x100, lsu_rs2_value_o = 0, lsu_rob_tag_o = 3.
- SW with rs2 not ready (tag 5); CDB broadcasts tag 5 with value 0xDEADBEEF two cycles later -> request exactly one cycle after the wakeup edge, lsu_rs2_value_o = 0xDEADBEEF.
- Head not ready (tag 7) and second entry ready -> no request until tag 7 is broadcast, then two requests in back-to-back cycles in program order.
- Fill 4 entries with lsu_busy_i = 1 -> disp_ready_o = 0 and count_o = 4; a 5th dispatch is ignored. Drop lsu_busy_i -> 4 consecutive pulses, and pointer wrap is verified by 4 further dispatches and issues.
- Dispatch with rs1 tag 9 not ready while the CDB broadcasts tag 9 with value 0x44 in the same cycle -> entry captures 0x44 and issues 2 cycles later.
- flush_i with 3 entries queued and an issue pending -> next cycle count_o = 0, lsu_request_o = 0; reset_i asserted mid-burst -> outputs go to 0 asynchronously, before the next clock edge.
